// File: rtl/slot_reel_controller_pkg.sv
// Shared types and helpers for the slot reel controller.
// State encodings are fixed so the top level can decode them if it ever needs to.
package slot_reel_controller_pkg;

  localparam int unsigned MaxReels = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSpin = 2'd1,
    StEval = 2'd2
  } state_e;

  // Per-cycle advance of reel idx: odd steps so every reel visits every symbol.
  function automatic int unsigned reel_step(int unsigned idx, int unsigned sym_bits);
    return (2 * idx + 1) % (32'd1 << sym_bits);
  endfunction

endpackage

// File: rtl/slot_reel_controller_if.sv
// Board-side signal bundle of the slot reel controller: keys and switches in, display data out.
interface slot_reel_controller_if #(
  parameter int unsigned NUM_REELS = 3,
  parameter int unsigned SYM_BITS  = 2,
  parameter int unsigned CREDIT_W  = 5,
  parameter int unsigned LOAD_W    = 3
);

  logic                          load_en;
  logic [LOAD_W-1:0]             load_val;
  logic                          withdraw;
  logic                          start_key;
  logic                          stop_key;
  logic [CREDIT_W-1:0]           credit;
  logic [NUM_REELS*SYM_BITS-1:0] reels;
  logic                          spinning;
  logic                          win;

  modport master (
    output load_en,
    output load_val,
    output withdraw,
    output start_key,
    output stop_key,
    input  credit,
    input  reels,
    input  spinning,
    input  win
  );

  modport slave (
    input  load_en,
    input  load_val,
    input  withdraw,
    input  start_key,
    input  stop_key,
    output credit,
    output reels,
    output spinning,
    output win
  );

endinterface

// File: rtl/slot_reel_controller_key_edge_sync.sv
// Synchronises an active-low push key and emits a one-cycle pulse per press.
// A hold produces a single pulse; synchronisers reset to the released level.
module slot_reel_controller_key_edge_sync (
  input  logic clk,
  input  logic Clear_b,
  input  logic key,
  output logic press
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk or negedge Clear_b) begin
    if (!Clear_b) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= key;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign press = s3_q & ~s2_q;

endmodule

// File: rtl/slot_reel_controller.sv
// N-reel slot game core: credit keeping, reel spin/stop sequencing and win evaluation.
// Reels are stopped in order 0..N-1 by the stop key or by an idle timeout.
module slot_reel_controller
  import slot_reel_controller_pkg::*;
#(
  parameter int unsigned NUM_REELS   = 3,
  parameter int unsigned SYM_BITS    = 2,
  parameter int unsigned CREDIT_W    = 5,
  parameter int unsigned LOAD_W      = 3,
  parameter int unsigned JACKPOT_PAY = 2,
  parameter int unsigned PAIR_PAY    = 0,
  parameter int unsigned AUTO_STOP   = 1024
) (
  input logic                 clk,
  input logic                 Clear_b,
  slot_reel_controller_if.slave bus
);

  localparam int unsigned ReelsW = NUM_REELS * SYM_BITS;
  localparam int unsigned NrW    = $clog2(NUM_REELS + 1);
  localparam int unsigned CntW   = (AUTO_STOP > 1) ? $clog2(AUTO_STOP) : 1;
  localparam logic [NrW-1:0]  LastReel  = NrW'(NUM_REELS - 1);
  localparam logic [CntW-1:0] CntLimit  = CntW'(AUTO_STOP - 1);
  localparam logic [32:0]     CreditMax = (33'd1 << CREDIT_W) - 33'd1;

  if (LOAD_W > CREDIT_W) begin : g_bad_load_w
    $error("LOAD_W (%0d) must not exceed CREDIT_W (%0d)", LOAD_W, CREDIT_W);
  end
  if (NUM_REELS < 2 || NUM_REELS > MaxReels) begin : g_bad_num_reels
    $error("NUM_REELS (%0d) must be in 2..%0d", NUM_REELS, MaxReels);
  end
  if (SYM_BITS < 1) begin : g_bad_sym_bits
    $error("SYM_BITS must be at least 1");
  end

  function automatic logic [CREDIT_W-1:0] sat_add(logic [CREDIT_W-1:0] base, int unsigned pay);
    logic [32:0] sum;
    sum = 33'(base) + 33'(pay);
    return (sum > CreditMax) ? '1 : sum[CREDIT_W-1:0];
  endfunction

  state_e              state_q;
  logic [CREDIT_W-1:0] credit_q;
  logic [ReelsW-1:0]   reels_q;
  logic [ReelsW-1:0]   reels_adv;
  logic [NrW-1:0]      next_reel_q;
  logic [CntW-1:0]     auto_cnt_q;
  logic                win_q;
  logic                spinning_q;

  logic                 start_press;
  logic                 stop_press;
  logic                 timeout;
  logic                 stop_now;
  logic [NUM_REELS-1:0] advance;
  logic [NUM_REELS-1:0] eq_first;
  logic                 all_equal;
  logic                 pair_equal;

  slot_reel_controller_key_edge_sync u_start_sync (
    .clk    (clk),
    .Clear_b(Clear_b),
    .key    (bus.start_key),
    .press  (start_press)
  );

  slot_reel_controller_key_edge_sync u_stop_sync (
    .clk    (clk),
    .Clear_b(Clear_b),
    .key    (bus.stop_key),
    .press  (stop_press)
  );

  // A press and a timeout landing together still stop only one reel.
  assign timeout  = (AUTO_STOP != 0) && (auto_cnt_q == CntLimit);
  assign stop_now = stop_press | timeout;

  for (genvar g = 0; g < NUM_REELS; g++) begin : g_reel
    localparam logic [SYM_BITS-1:0] Step = SYM_BITS'(reel_step(g, SYM_BITS));

    // The reel being stopped this cycle keeps the value it shows now.
    assign advance[g] = (NrW'(g) > next_reel_q) || ((NrW'(g) == next_reel_q) && !stop_now);
    assign reels_adv[g*SYM_BITS +: SYM_BITS] = advance[g]
        ? reels_q[g*SYM_BITS +: SYM_BITS] + Step
        : reels_q[g*SYM_BITS +: SYM_BITS];
    assign eq_first[g] = (reels_q[g*SYM_BITS +: SYM_BITS] == reels_q[0 +: SYM_BITS]);
  end

  assign all_equal  = &eq_first;
  assign pair_equal = (reels_q[0 +: SYM_BITS] == reels_q[SYM_BITS +: SYM_BITS]);

  always_ff @(posedge clk or negedge Clear_b) begin
    if (!Clear_b) begin
      state_q     <= StIdle;
      credit_q    <= '0;
      reels_q     <= '0;
      next_reel_q <= '0;
      auto_cnt_q  <= '0;
      win_q       <= 1'b0;
      spinning_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.withdraw) begin
            credit_q <= '0;
            win_q    <= 1'b0;
          end else if (bus.load_en) begin
            credit_q <= CREDIT_W'(bus.load_val);
            win_q    <= 1'b0;
          end else if (start_press && (credit_q != '0)) begin
            credit_q    <= credit_q - CREDIT_W'(1);
            win_q       <= 1'b0;
            next_reel_q <= '0;
            auto_cnt_q  <= '0;
            state_q     <= StSpin;
            spinning_q  <= 1'b1;
          end
        end
        StSpin: begin
          reels_q <= reels_adv;
          if (stop_now) begin
            next_reel_q <= next_reel_q + NrW'(1);
            auto_cnt_q  <= '0;
            if (next_reel_q == LastReel) begin
              state_q    <= StEval;
              spinning_q <= 1'b0;
            end
          end else begin
            auto_cnt_q <= auto_cnt_q + CntW'(1);
          end
        end
        StEval: begin
          if (all_equal) begin
            credit_q <= sat_add(credit_q, JACKPOT_PAY);
            win_q    <= 1'b1;
          end else if ((PAIR_PAY != 0) && pair_equal) begin
            credit_q <= sat_add(credit_q, PAIR_PAY);
            win_q    <= 1'b1;
          end else begin
            win_q <= 1'b0;
          end
          state_q <= StIdle;
        end
        default: begin
          state_q    <= StIdle;
          spinning_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.credit   = credit_q;
  assign bus.reels    = reels_q;
  assign bus.spinning = spinning_q;
  assign bus.win      = win_q;

endmodule
